convn_valid_tap_acc: RTL and testbench

Downstream neighbour of the signed `convn_valid` multiplier. It takes the stream of signed kernel-tap products, sums each group of `TAPS` consecutive products, and emits one output pixel per group. Input and output use valid/ready handshakes. The result is held in a one-entry output register so the multiplier pipeline keeps running while the consumer stalls.

---
 rtl/convn_valid_tap_acc.sv | 101 ++++++++++
 tb/tb_convn_valid_tap_acc.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/convn_valid_tap_acc.sv
// Tap accumulator behind the signed convn_valid multiplier: sums each group of
// TAPS signed products into one pixel and holds it in a one-entry output register.
module convn_valid_tap_acc #(
    parameter int DIN_WIDTH = 10,
    parameter int ACC_WIDTH = 10,
    parameter int TAPS      = 9,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [DIN_WIDTH-1:0] prod_din,
    input  logic                 prod_valid,
    output logic                 prod_ready,
    output logic [ACC_WIDTH-1:0] sum_dout,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic                 busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] LAST_TAP = CNT_WIDTH'(TAPS - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};

    function automatic logic [ACC_WIDTH-1:0] sign_ext(input logic [DIN_WIDTH-1:0] d);
        logic [ACC_WIDTH-1:0] r;
        r                = {ACC_WIDTH{d[DIN_WIDTH-1]}};
        r[DIN_WIDTH-1:0] = d;
        return r;
    endfunction

    logic [CNT_WIDTH-1:0] tap_cnt_r;
    logic [ACC_WIDTH-1:0] acc_r;
    logic [ACC_WIDTH-1:0] sum_r;
    logic                 sum_valid_r;

    logic [ACC_WIDTH-1:0] din_ext_s;
    logic [ACC_WIDTH-1:0] tap_sum_s;
    logic                 is_first_s;
    logic                 is_last_s;
    logic                 prod_ready_s;
    logic                 accept_s;
    logic                 out_take_s;

    // Handshake decode and running sum including the product on the bus.
    always_comb begin
        din_ext_s    = sign_ext(prod_din);
        is_first_s   = (tap_cnt_r == CNT_ZERO);
        is_last_s    = (tap_cnt_r == LAST_TAP);
        // Only the last tap waits, and only for a blocked result.
        prod_ready_s = !is_last_s || !sum_valid_r || sum_ready;
        accept_s     = prod_valid && prod_ready_s;
        out_take_s   = sum_valid_r && sum_ready;
        if (is_first_s) begin
            tap_sum_s = din_ext_s;
        end else begin
            tap_sum_s = acc_r + din_ext_s;
        end
    end

    // Tap counter and partial accumulator.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            tap_cnt_r <= CNT_ZERO;
            acc_r     <= ACC_ZERO;
        end else if (accept_s) begin
            acc_r <= tap_sum_s;
            if (is_last_s) begin
                tap_cnt_r <= CNT_ZERO;
            end else begin
                tap_cnt_r <= tap_cnt_r + CNT_ONE;
            end
        end else begin
            tap_cnt_r <= tap_cnt_r;
            acc_r     <= acc_r;
        end
    end

    // One-entry output register; a reload in the same cycle as a take keeps valid high.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            sum_r       <= ACC_ZERO;
            sum_valid_r <= 1'b0;
        end else if (accept_s && is_last_s) begin
            sum_r       <= tap_sum_s;
            sum_valid_r <= 1'b1;
        end else if (out_take_s) begin
            sum_r       <= sum_r;
            sum_valid_r <= 1'b0;
        end else begin
            sum_r       <= sum_r;
            sum_valid_r <= sum_valid_r;
        end
    end

    assign prod_ready = prod_ready_s;
    assign sum_dout   = sum_r;
    assign sum_valid  = sum_valid_r;
    assign busy       = !is_first_s;

endmodule

// File: tb/tb_convn_valid_tap_acc.sv
// Self-checking bench: table-driven pixels, hand-written corner sequences and a
// randomized run, all compared against a queue-based pixel model.
module tb_convn_valid_tap_acc;

    localparam int DW   = 10;
    localparam int AW   = 10;
    localparam int TAPS = 9;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic [DW-1:0] prod_din = '0;
    logic          prod_valid = 1'b0;
    logic          prod_ready;
    logic [AW-1:0] sum_dout;
    logic          sum_valid;
    logic          sum_ready = 1'b0;
    logic          busy;

    logic [DW-1:0] p1_din = '0;
    logic          p1_valid = 1'b0;
    logic          p1_ready;
    logic [AW-1:0] p1_dout;
    logic          p1_svalid;
    logic          p1_sready = 1'b0;
    logic          p1_busy;

    int errors = 0;
    int checks = 0;

    always #5 ap_clk = ~ap_clk;

    convn_valid_tap_acc #(.DIN_WIDTH(DW), .ACC_WIDTH(AW), .TAPS(TAPS), .CNT_WIDTH(4)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .prod_din(prod_din), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .sum_dout(sum_dout), .sum_valid(sum_valid), .sum_ready(sum_ready), .busy(busy)
    );

    convn_valid_tap_acc #(.DIN_WIDTH(DW), .ACC_WIDTH(AW), .TAPS(1), .CNT_WIDTH(1)) dut1 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .prod_din(p1_din), .prod_valid(p1_valid), .prod_ready(p1_ready),
        .sum_dout(p1_dout), .sum_valid(p1_svalid), .sum_ready(p1_sready), .busy(p1_busy)
    );

    // Pixel model: products of the pixel in progress plus the pending result.
    int pix_q[$];
    bit m_valid = 1'b0;
    int m_sum   = 0;

    function automatic int wrap(input int s);
        logic [AW-1:0] t;
        t = s[AW-1:0];
        return int'($signed(t));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock on the TAPS=9 instance, checked against the model.
    task automatic cyc(input bit v, input int d, input bit sr);
        bit exp_rdy;
        int s;
        prod_valid = v;
        prod_din   = d[DW-1:0];
        sum_ready  = sr;
        #1;
        exp_rdy = (pix_q.size() != TAPS - 1) || !m_valid || sr;
        chk("prod_ready", int'(prod_ready), int'(exp_rdy));
        if (v && exp_rdy) begin
            pix_q.push_back(d);
            if (pix_q.size() == TAPS) begin
                s = 0;
                foreach (pix_q[i]) s += pix_q[i];
                m_sum   = wrap(s);
                m_valid = 1'b1;
                pix_q.delete();
            end else if (m_valid && sr) begin
                m_valid = 1'b0;
            end
        end else if (m_valid && sr) begin
            m_valid = 1'b0;
        end
        @(posedge ap_clk);
        #1;
        chk("sum_valid", int'(sum_valid), int'(m_valid));
        if (m_valid) chk("sum_dout", int'($signed(sum_dout)), m_sum);
        chk("busy", int'(busy), int'(pix_q.size() != 0));
    endtask

    task automatic do_reset();
        ap_rst     = 1'b1;
        prod_valid = 1'b0;
        p1_valid   = 1'b0;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        pix_q.delete();
        m_valid = 1'b0;
        m_sum   = 0;
        chk("rst_sum_valid", int'(sum_valid), 0);
        chk("rst_sum_dout", int'($signed(sum_dout)), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_prod_ready", int'(prod_ready), 1);
        chk("rst1_sum_valid", int'(p1_svalid), 0);
    endtask

    typedef struct {
        string name;
        int    prod[TAPS];
        int    exp_sum;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0].name = "ones";    vecs[0].prod = '{1, 1, 1, 1, 1, 1, 1, 1, 1};             vecs[0].exp_sum = 9;
        vecs[1].name = "wrap100"; vecs[1].prod = '{100, 100, 100, 100, 100, 100, 100, 100, 100}; vecs[1].exp_sum = -124;
        vecs[2].name = "neg512";  vecs[2].prod = '{-512, -512, -512, -512, -512, -512, -512, -512, -512}; vecs[2].exp_sum = -512;
        vecs[3].name = "ramp";    vecs[3].prod = '{1, 2, 3, 4, 5, 6, 7, 8, 9};             vecs[3].exp_sum = 45;
        vecs[4].name = "mixed";   vecs[4].prod = '{-1, 511, -300, 7, 0, 20, -100, 3, -2}; vecs[4].exp_sum = 138;

        repeat (2) @(posedge ap_clk);
        #1;
        do_reset();

        // Table-driven pixels, back-to-back with the consumer always ready.
        for (int v = 0; v < 5; v++) begin
            for (int t = 0; t < TAPS; t++) cyc(1'b1, vecs[v].prod[t], 1'b1);
            chk({"tbl_valid_", vecs[v].name}, int'(sum_valid), 1);
            chk({"tbl_sum_", vecs[v].name}, int'($signed(sum_dout)), vecs[v].exp_sum);
        end
        cyc(1'b0, 0, 1'b1);
        chk("single_cycle_valid", int'(sum_valid), 0);
        chk("idle_busy", int'(busy), 0);

        // Back-pressure: 17 taps of 2 with the consumer stalled, last tap blocked.
        for (int t = 0; t < 17; t++) cyc(1'b1, 2, 1'b0);
        chk("bp_held_sum", int'($signed(sum_dout)), 18);
        cyc(1'b1, 2, 1'b0);
        prod_valid = 1'b1;
        #1;
        chk("bp_last_stalled", int'(prod_ready), 0);
        cyc(1'b1, 2, 1'b1);
        chk("bp_no_gap_valid", int'(sum_valid), 1);
        chk("bp_second_sum", int'($signed(sum_dout)), 18);
        cyc(1'b0, 0, 1'b1);
        chk("bp_drained", int'(sum_valid), 0);

        // Gaps: prod_valid low for 3 cycles after the 4th product.
        for (int t = 1; t <= 4; t++) cyc(1'b1, t, 1'b1);
        for (int g = 0; g < 3; g++) begin
            cyc(1'b0, 77, 1'b1);
            chk("gap_busy", int'(busy), 1);
        end
        for (int t = 5; t <= 9; t++) cyc(1'b1, t, 1'b1);
        chk("gap_sum", int'($signed(sum_dout)), 45);
        cyc(1'b0, 0, 1'b1);

        // Reset mid-pixel, with a held result too.
        cyc(1'b1, 5, 1'b0);
        for (int t = 0; t < 8; t++) cyc(1'b1, 5, 1'b0);
        for (int t = 0; t < 5; t++) cyc(1'b1, 7, 1'b0);
        do_reset();
        for (int t = 0; t < TAPS; t++) cyc(1'b1, 3, 1'b1);
        chk("post_rst_sum", int'($signed(sum_dout)), 27);
        cyc(1'b0, 0, 1'b1);

        // TAPS = 1 instance: each product is its own pixel.
        begin
            int seq[3];
            seq = '{-3, 5, 0};
            p1_sready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                p1_valid = 1'b1;
                p1_din   = seq[i][DW-1:0];
                #1;
                chk("t1_ready", int'(p1_ready), 1);
                @(posedge ap_clk);
                #1;
                chk("t1_valid", int'(p1_svalid), 1);
                chk("t1_sum", int'($signed(p1_dout)), seq[i]);
                chk("t1_busy", int'(p1_busy), 0);
            end
            p1_valid = 1'b0;
            @(posedge ap_clk);
            #1;
            chk("t1_drained", int'(p1_svalid), 0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 9) < 7), int'($urandom_range(0, 1023)) - 512, ($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 12; i++) cyc(1'b0, 0, 1'b1);
        chk("final_idle_valid", int'(sum_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
